aes_key_gen: RTL and testbench
==============================

AES_KEY_GEN -- requirements
Module: aes_key_gen

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset, with ports: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-002 The block SHALL have port gen_key_i  in  1  load cipher key from key_i and restart the schedule.
REQ-003 The block SHALL have port next_rnd_i  in  1  request expansion of the next round key.
REQ-004 The block SHALL have port key_i  in  128  cipher key; key_i[127:96]=w0, key_i[31:0]=w3, MSB byte first.
REQ-005 The block SHALL have port sbox_in_o  out  32  word to the shared combinational S-box (4 bytes).
REQ-006 The block SHALL have port sbox_out_i  in  32  substituted word returned in the same cycle.
REQ-007 The block SHALL have port round_key_o  out  128  current round key.
REQ-008 The block SHALL have port round_o  out  4  index of round_key_o (0..10).
REQ-009 The block SHALL have port key_valid_o  out  1  round_key_o is stable and usable.
REQ-010 The block SHALL have port busy_o  out  1  expansion in progress.
REQ-011 The block SHALL have port last_rnd_o  out  1  round_o==10 and key_valid_o.

Function
REQ-012 The FSM SHALL have states IDLE, SUB and EXPAND.
REQ-013 IDLE + gen_key_i: next cycle round_key_o=key_i, round_o=0, rcon=0x01, key_valid_o=1; state stays IDLE.
REQ-014 IDLE + next_rnd_i + key_valid_o + round_o<10: go to SUB; key_valid_o=0 and busy_o=1 from the next cycle.
REQ-015 In SUB, sbox_in_o SHALL equal RotWord(w3)={w3[23:0],w3[31:24]}; sbox_out_i is registered into a temp word; next state is EXPAND.
REQ-016 In EXPAND, the block SHALL compute w0'=w0^temp^{rcon,24'h0}, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'; it SHALL then register the key, increment round_o, advance rcon (xtime: shift left, XOR 0x1b on carry-out) and return to IDLE with key_valid_o=1.
REQ-017 The new key SHALL be valid exactly 3 cycles after the accepting edge (SUB, EXPAND, write).
REQ-018 Outside SUB, sbox_in_o SHALL be 0.
REQ-019 next_rnd_i when round_o==10, when key_valid_o==0 or when not in IDLE SHALL be ignored with no state change.
REQ-020 If gen_key_i and next_rnd_i are asserted in the same cycle, gen_key_i SHALL win.
REQ-021 gen_key_i in SUB or EXPAND SHALL abort the expansion and reload as in REQ-013; the partial result SHALL be discarded.
REQ-022 The rcon sequence SHALL be 01,02,04,08,10,20,40,80,1b,36 for rounds 1..10.

Reset
REQ-023 rst SHALL force, at the next edge: state IDLE, round_key_o=0, round_o=0, rcon=0x01, key_valid_o=0, busy_o=0, last_rnd_o=0, temp=0.
REQ-024 rst SHALL take priority over gen_key_i and next_rnd_i, including mid-expansion.

Configuration
REQ-025 With macro AES_KEYGEN_KEY_STORE_EN defined, the block SHALL add ports key_idx_i (in, 4) and stored_key_o (out, 128) and an 11-entry store written with each new round key; reads SHALL be combinational, and indices above 10 SHALL read 0.
REQ-026 With AES_KEYGEN_KEY_STORE_EN defined, gen_key_i and rst SHALL clear entries 1..10 to 0.
REQ-027 Without AES_KEYGEN_KEY_STORE_EN, those ports and the store SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-028 Bench SHALL cover: gen_key_i with key 2b7e151628aed2a6abf7158809cf4f3c, then one next_rnd_i -> 3 cycles later round_key_o=a0fafe1788542cb123a339392a6c7605, round_o=1.
REQ-029 Bench SHALL cover: 10 consecutive expansions from the same key -> round 10 key d014f9a8c9ee2589e13f0cc8b6630ca6, last_rnd_o=1; an 11th next_rnd_i is ignored.
REQ-030 Bench SHALL cover: next_rnd_i pulsed during SUB and EXPAND -> ignored, exactly one increment of round_o.
REQ-031 Bench SHALL cover: gen_key_i asserted during EXPAND -> next cycle round_key_o=key_i, round_o=0, rcon restarts at 0x01.
REQ-032 Bench SHALL cover: rst asserted in SUB -> all outputs 0 the next cycle, and next_rnd_i is ignored until a gen_key_i.
REQ-033 Bench SHALL cover, with AES_KEYGEN_KEY_STORE_EN defined: key_idx_i=1 after round 10 -> a0fafe17...; key_idx_i=12 -> 0.

Source files
------------

// File: rtl/aes_key_gen.sv
// -----------------------------------------------------------------------------
// aes_key_gen -- iterative AES-128 round-key generator.
//
// Expands a 128-bit cipher key one round at a time, on request, using an
// external combinational S-box shared with the cipher datapath. Each round
// takes three cycles from the request edge: SUB (S-box lookup of RotWord(w3)),
// EXPAND (word chain XOR) and the write of the new key.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   gen_key_i    load key_i as round 0 and restart the schedule (aborts any
//                expansion in flight)
//   next_rnd_i   request the next round key (honoured only in IDLE with a
//                valid key below round 10)
//   key_i        cipher key, w0 in [127:96] ... w3 in [31:0]
//   sbox_in_o    word presented to the shared S-box (0 outside SUB)
//   sbox_out_i   substituted word, returned combinationally
//   round_key_o  current round key
//   round_o      index of round_key_o (0..10)
//   key_valid_o  round_key_o is stable and usable
//   busy_o       expansion in progress
//   last_rnd_o   round 10 key is valid
//
// Optional feature, enabled by defining AES_KEYGEN_KEY_STORE_EN:
//   key_idx_i    store read index (0..10, larger indices read 0)
//   stored_key_o combinational read of the 11-entry round-key store
// -----------------------------------------------------------------------------
module aes_key_gen (
    input  logic         clk,
    input  logic         rst,
    input  logic         gen_key_i,
    input  logic         next_rnd_i,
    input  logic [127:0] key_i,
    output logic [31:0]  sbox_in_o,
    input  logic [31:0]  sbox_out_i,
    output logic [127:0] round_key_o,
    output logic [3:0]   round_o,
    output logic         key_valid_o,
    output logic         busy_o,
    output logic         last_rnd_o
`ifdef AES_KEYGEN_KEY_STORE_EN
    ,
    input  logic [3:0]   key_idx_i,
    output logic [127:0] stored_key_o
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SUB    = 2'd1,
        EXPAND = 2'd2
    } state_t;

    state_t         state_reg;
    state_t         state_next;
    logic [127:0]   round_key_reg;
    logic [3:0]     round_reg;
    logic [7:0]     rcon_reg;
    logic [7:0]     rcon_next;
    logic           valid_reg;
    logic [31:0]    temp_reg;
    logic [31:0]    w_cur  [4];
    logic [31:0]    w_next [4];
    logic [127:0]   key_next;
    logic           accept;

    // Split the key into words, w0 being the most significant.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_words
            assign w_cur[gi] = round_key_reg[127-32*gi -: 32];
            if (gi == 0) begin : g_w0
                assign w_next[gi] = w_cur[gi] ^ temp_reg ^ {rcon_reg, 24'h0};
            end else begin : g_wn
                assign w_next[gi] = w_cur[gi] ^ w_next[gi-1];
            end
            assign key_next[127-32*gi -: 32] = w_next[gi];
        end
    endgenerate

    // xtime: multiply by x in GF(2^8) with the AES polynomial.
    assign rcon_next = {rcon_reg[6:0], 1'b0} ^ (rcon_reg[7] ? 8'h1b : 8'h00);

    assign accept = (state_reg == IDLE) && next_rnd_i && valid_reg && (round_reg != 4'd10);

    always_comb begin
        state_next = state_reg;
        sbox_in_o  = 32'h0;
        case (state_reg)
            IDLE:    if (accept) state_next = SUB;
            SUB: begin
                sbox_in_o  = {w_cur[3][23:0], w_cur[3][31:24]};
                state_next = EXPAND;
            end
            EXPAND:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // A reload always returns to IDLE, abandoning any partial round.
        if (gen_key_i) state_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            round_key_reg <= 128'h0;
            round_reg     <= 4'd0;
            rcon_reg      <= 8'h01;
            valid_reg     <= 1'b0;
            temp_reg      <= 32'h0;
        end else if (gen_key_i) begin
            round_key_reg <= key_i;
            round_reg     <= 4'd0;
            rcon_reg      <= 8'h01;
            valid_reg     <= 1'b1;
            temp_reg      <= 32'h0;
        end else begin
            case (state_reg)
                IDLE:   if (accept) valid_reg <= 1'b0;
                SUB:    temp_reg <= sbox_out_i;
                EXPAND: begin
                    round_key_reg <= key_next;
                    round_reg     <= round_reg + 4'd1;
                    rcon_reg      <= rcon_next;
                    valid_reg     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign round_key_o = round_key_reg;
    assign round_o     = round_reg;
    assign key_valid_o = valid_reg;
    assign busy_o      = (state_reg != IDLE);
    assign last_rnd_o  = valid_reg && (round_reg == 4'd10);

`ifdef AES_KEYGEN_KEY_STORE_EN
    // Register-based store: reads are combinational and a reload must clear
    // ten entries at once, which a RAM cannot do.
    logic [127:0] store_reg [0:10];
    logic [3:0]   round_inc;

    assign round_inc = round_reg + 4'd1;

    always_ff @(posedge clk) begin
        for (int i = 0; i <= 10; i++) begin
            if (rst) begin
                store_reg[i] <= 128'h0;
            end else if (gen_key_i) begin
                store_reg[i] <= (i == 0) ? key_i : 128'h0;
            end else if (state_reg == EXPAND && round_inc == i[3:0]) begin
                store_reg[i] <= key_next;
            end
        end
    end

    assign stored_key_o = (key_idx_i <= 4'd10) ? store_reg[key_idx_i] : 128'h0;
`endif

endmodule

// File: tb/tb_aes_key_gen.sv
// -----------------------------------------------------------------------------
// tb_aes_key_gen -- scoreboard bench for aes_key_gen.
// The stimulus process pushes the expected {key, round, cycle} of every key
// the DUT should publish; the monitor pops and compares whenever a new valid
// key appears. Status outputs in between are checked directly.
// -----------------------------------------------------------------------------
module tb_aes_key_gen;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         gen_key_i = 1'b0;
    logic         next_rnd_i = 1'b0;
    logic [127:0] key_i = 128'h0;
    logic [31:0]  sbox_in_o;
    logic [31:0]  sbox_out_i;
    logic [127:0] round_key_o;
    logic [3:0]   round_o;
    logic         key_valid_o;
    logic         busy_o;
    logic         last_rnd_o;
`ifdef AES_KEYGEN_KEY_STORE_EN
    logic [3:0]   key_idx_i = 4'd0;
    logic [127:0] stored_key_o;
`endif

    aes_key_gen dut (
        .clk         (clk),
        .rst         (rst),
        .gen_key_i   (gen_key_i),
        .next_rnd_i  (next_rnd_i),
        .key_i       (key_i),
        .sbox_in_o   (sbox_in_o),
        .sbox_out_i  (sbox_out_i),
        .round_key_o (round_key_o),
        .round_o     (round_o),
        .key_valid_o (key_valid_o),
        .busy_o      (busy_o),
        .last_rnd_o  (last_rnd_o)
`ifdef AES_KEYGEN_KEY_STORE_EN
        ,
        .key_idx_i   (key_idx_i),
        .stored_key_o(stored_key_o)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] KEY_A  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_A1 = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] KEY_A10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] KEY_B  = 128'h000102030405060708090a0b0c0d0e0f;

    // ---------------- reference S-box (GF inverse + affine) -----------------
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a = a_in;
        logic [7:0] b = b_in;
        logic [7:0] p = 8'h0;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
        return 8'((b << k) | (b >> (8 - k)));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gmul(inv, x);
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    always_comb sbox_out_i = sub_word(sbox_in_o);

    // ---------------- reference key schedule --------------------------------
    function automatic logic [127:0] model_next(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        t  = sub_word({k[23:0], k[31:24]});
        w0 = k[127:96] ^ t ^ {rc, 24'h0};
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
    endfunction

    // ---------------- scoreboard --------------------------------------------
    typedef struct {
        logic [127:0] key;
        logic [3:0]   round;
        int           at;
    } exp_t;
    exp_t exp_q[$];

    logic         prev_valid = 1'b0;
    logic [127:0] prev_key = 128'h0;
    logic [3:0]   prev_round = 4'd0;

    always @(negedge clk) begin
        exp_t e;
        if (!rst && key_valid_o === 1'b1 &&
            (!prev_valid || round_key_o !== prev_key || round_o !== prev_round)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_key: got round %0d key %h at cycle %0d, none expected",
                         round_o, round_key_o, cyc);
            end else begin
                e = exp_q.pop_front();
                if (round_key_o !== e.key || round_o !== e.round || cyc != e.at) begin
                    errors++;
                    $display("FAIL key_round%0d: got key %h round %0d cycle %0d, expected key %h round %0d cycle %0d",
                             e.round, round_key_o, round_o, cyc, e.key, e.round, e.at);
                end else begin
                    $display("key round %0d = %h at cycle %0d ok", round_o, round_key_o, cyc);
                end
            end
        end
        prev_valid = (key_valid_o === 1'b1) && !rst;
        prev_key   = round_key_o;
        prev_round = round_o;
    end

    // ---------------- stimulus helpers --------------------------------------
    logic [127:0] m_key;
    logic [7:0]   m_rcon;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end else begin
            $display("check %s = %h ok", name, act);
        end
    endtask

    task automatic load_key(input logic [127:0] k);
        gen_key_i = 1'b1;
        key_i     = k;
        exp_q.push_back('{key: k, round: 4'd0, at: cyc + 1});
        m_key  = k;
        m_rcon = 8'h01;
        tick();
        gen_key_i = 1'b0;
    endtask

    // One-cycle next_rnd_i pulse; the expected key (if any) is queued.
    task automatic req_round(input logic push, input logic [127:0] k, input logic [3:0] r);
        next_rnd_i = 1'b1;
        if (push) exp_q.push_back('{key: k, round: r, at: cyc + 3});
        tick();
        next_rnd_i = 1'b0;
    endtask

    task automatic wait_valid();
        for (int n = 0; n < 8 && key_valid_o !== 1'b1; n++) tick();
        checks++;
        if (key_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL wait_valid: key_valid_o still %b after timeout", key_valid_o);
        end
    endtask

    // ---------------- stimulus ----------------------------------------------
    initial begin
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("reset_round_key", round_key_o, 128'h0);
        check("reset_round", 128'(round_o), 128'h0);
        check("reset_valid_busy_last", 128'({key_valid_o, busy_o, last_rnd_o}), 128'h0);
        check("reset_sbox_in", 128'(sbox_in_o), 128'h0);

        // Load, then first round with SUB/EXPAND observation.
        load_key(KEY_A);
        m_key  = model_next(m_key, m_rcon);
        m_rcon = xtime(m_rcon);
        req_round(1'b1, KEY_A1, 4'd1);
        check("sub_valid_busy", 128'({key_valid_o, busy_o}), 128'b01);
        check("sub_sbox_in", 128'(sbox_in_o), 128'hcf4f3c09);
        tick();
        check("expand_sbox_in", 128'(sbox_in_o), 128'h0);
        wait_valid();

        // Rounds 2..10.
        for (int r = 2; r <= 10; r++) begin
            m_key  = model_next(m_key, m_rcon);
            m_rcon = xtime(m_rcon);
            req_round(1'b1, (r == 10) ? KEY_A10 : m_key, 4'(r));
            wait_valid();
        end
        check("last_rnd", 128'(last_rnd_o), 128'h1);

        // 11th request is ignored.
        req_round(1'b0, 128'h0, 4'd0);
        tick();
        tick();
        check("ignored_11th", 128'({round_o, busy_o, key_valid_o}), 128'({4'd10, 1'b0, 1'b1}));
`ifdef AES_KEYGEN_KEY_STORE_EN
        key_idx_i = 4'd1;
        #1 check("store_idx1", stored_key_o, KEY_A1);
        key_idx_i = 4'd10;
        #1 check("store_idx10", stored_key_o, KEY_A10);
        key_idx_i = 4'd12;
        #1 check("store_idx12", stored_key_o, 128'h0);
`endif

        // next_rnd_i held through SUB and EXPAND: exactly one increment.
        load_key(KEY_A);
        next_rnd_i = 1'b1;
        exp_q.push_back('{key: KEY_A1, round: 4'd1, at: cyc + 3});
        tick();
        tick();
        tick();
        next_rnd_i = 1'b0;
        tick();
        tick();
        check("held_next_one_incr", 128'({round_o, busy_o}), 128'({4'd1, 1'b0}));

        // gen_key_i during EXPAND aborts and reloads; rcon restarts.
        req_round(1'b0, 128'h0, 4'd0);
        tick();
        gen_key_i = 1'b1;
        key_i     = KEY_B;
        exp_q.push_back('{key: KEY_B, round: 4'd0, at: cyc + 1});
        tick();
        gen_key_i = 1'b0;
        check("abort_reload_round", 128'({round_o, busy_o, key_valid_o}), 128'({4'd0, 1'b0, 1'b1}));
        req_round(1'b1, model_next(KEY_B, 8'h01), 4'd1);
        wait_valid();

        // gen_key_i wins over a simultaneous next_rnd_i.
        gen_key_i  = 1'b1;
        next_rnd_i = 1'b1;
        key_i      = KEY_A;
        exp_q.push_back('{key: KEY_A, round: 4'd0, at: cyc + 1});
        tick();
        gen_key_i  = 1'b0;
        next_rnd_i = 1'b0;
        tick();
        check("gen_wins", 128'({round_o, busy_o}), 128'({4'd0, 1'b0}));

        // rst in SUB clears everything; later next_rnd_i is ignored.
        req_round(1'b0, 128'h0, 4'd0);
        check("pre_rst_busy", 128'(busy_o), 128'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_sub_key", round_key_o, 128'h0);
        check("rst_sub_flags", 128'({round_o, key_valid_o, busy_o, last_rnd_o}), 128'h0);
        check("rst_sub_sbox_in", 128'(sbox_in_o), 128'h0);
        req_round(1'b0, 128'h0, 4'd0);
        tick();
        tick();
        tick();
        check("after_rst_ignored", 128'({round_o, key_valid_o, busy_o}), 128'h0);

        tick();
        check("queue_drained", 128'(exp_q.size()), 128'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
